alu_serial_seq: RTL and testbench
=================================

# alu_serial_seq

Bit-serial sequencer that drives one `ALU_1bit` slice over `WIDTH` cycles to perform a full-width ALU operation. It sits directly upstream of the slice: it shifts operand bits in, registers the slice carry between cycles, and assembles result and flags. A simple start/done handshake connects it to the datapath.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; legal range 2..64.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; accepted on an edge where `start_i & ready_o`.
- `ready_o`  out  1  high in IDLE and DONE.
- `op_i`  in  4  operation code.
- `src1_i`, `src2_i`  in  WIDTH  operands A and B.
- `result_o`  out  WIDTH  registered result.
- `zero_o`  out  1  `result_o == 0`.
- `cout_o`  out  1  carry out of the MSB.
- `overflow_o`  out  1  signed overflow.
- `err_o`  out  1  illegal `op_i` captured.
- `done_o`  out  1  one-cycle pulse; result and flags valid.
- `slice_a_o`, `slice_b_o`, `slice_cin_o`  out  1  current bit of A, raw bit of B, and carry-in to the slice.
- `slice_op_o`  out  4  operation code presented to the slice.
- `slice_less_o`  out  1  tied 0.
- `slice_result_i`, `slice_cout_i`  in  1  slice sum/logic bit and carry-out.

## Operation
- Op codes:
  - `4'b0001` ADDU
  - `4'b0010` SUBU
  - `4'b0100` AND
  - `4'b0110` OR
  - `4'b0111` SLT
  - Any other code is illegal.
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `result_o`=0, all flags 0, `done_o`=0, `ready_o`=1.
- Accept on `start_i & ready_o`:
  - Latch A and B into shift registers and latch the op.
  - Clear the bit counter.
  - Set the carry register to 1 for SUBU/SLT, else 0.
  - Clear `err_o`.
  - Go to RUN; an illegal op goes straight to DONE instead.
- RUN, one bit per cycle, LSB first:
  - The slice receives `slice_a_o`=A[0] of the shift register, `slice_b_o`=B[0] and `slice_cin_o`=carry register. The slice performs B inversion for subtraction.
  - `slice_op_o` = latched op, except SLT presents `4'b0010`.
  - Each edge shifts `slice_result_i` into the result register MSB and shifts A and B right.
  - Each edge loads `slice_cout_i` into the carry register and increments the counter.
  - On the edge with counter = `WIDTH-1`, go to DONE.
- Flags, set on the final RUN edge:
  - `cout_o` = `slice_cout_i`.
  - `overflow_o` = carry-in of MSB XOR `slice_cout_i`.
  - For SLT, `result_o` = {0…, MSB-sum XOR overflow}.
  - For AND/OR, `cout_o` and `overflow_o` are 0.
  - `zero_o` is computed from the final `result_o`.
- Illegal op: `result_o`=0, `err_o`=1, other flags 0.
- DONE: `done_o`=1 for exactly one cycle, then IDLE. A start accepted in DONE enters RUN directly.
- Outputs hold until the next acceptance.
- `start_i` during RUN is ignored; no queueing.
- Reset mid-RUN: next cycle is IDLE with all outputs at reset values. No `done_o` is produced for the aborted op.

## Timing
- Acceptance at edge k → RUN on edges k+1…k+WIDTH → `done_o` high in the cycle after edge k+WIDTH. Latency is WIDTH+1 cycles.
- Illegal op: `done_o` high in the cycle after edge k.
- Back-to-back throughput is one op per WIDTH+1 cycles.
- Slice ports are combinational from internal registers and valid throughout each RUN cycle. The slice path must close within one cycle.
- `result_o` and the flags change only on the final compute edge, on an illegal-op accept edge, or on reset.

## Configuration
- `ALU_SEQ_LOGIC_BYPASS_EN` defined:
  - AND/OR are computed in parallel from `src1_i`/`src2_i` on the acceptance edge, with no RUN phase.
  - The state goes directly to DONE, so `done_o` is high in the cycle after acceptance.
  - The slice is not exercised.
- Undefined: AND/OR run serially through the slice with latency WIDTH+1, the same as arithmetic ops.

## Test plan
- ADDU `0x00000005` + `0x00000003`, WIDTH=32 → `result_o`=`0x00000008`, `cout_o`=0, `zero_o`=0, `done_o` exactly 33 cycles after acceptance.
- ADDU `0xFFFFFFFF` + `0x00000001` → `result_o`=0, `zero_o`=1, `cout_o`=1, `overflow_o`=0. ADDU `0x7FFFFFFF` + 1 → `overflow_o`=1.
- SUBU 5 − 7 → `0xFFFFFFFE`, `cout_o`=0. SLT `0x80000000` vs `0x00000001` → `result_o`=1. SLT 7 vs 5 → 0.
- AND `0xF0F0F0F0` & `0xFF00FF00` → `0xF000F000`, `done_o` after 33 cycles (macro off) or 1 cycle (macro on). OR of the same operands → `0xFFF0FFF0`.
- Reset asserted at RUN bit 10 → next cycle `ready_o`=1, `result_o`=0, no `done_o`. `start_i` pulsed during RUN → ignored, original result unchanged.
- `op_i`=`4'b1111` → `done_o` one cycle after acceptance, `err_o`=1, `result_o`=0. Next legal op clears `err_o`.

Source files
------------

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer driving a single ALU_1bit slice.
// Operands are shifted LSB first through the slice over WIDTH cycles; the
// slice carry is registered between cycles and the result/flags are loaded
// into the output registers on the final compute edge.
// Optional feature macro: ALU_SEQ_LOGIC_BYPASS_EN (AND/OR computed in
// parallel on the acceptance edge, no RUN phase).
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             err_o,
  output logic             done_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic [3:0]       slice_op_o,
  output logic             slice_less_o,
  input  logic             slice_result_i,
  input  logic             slice_cout_i
);

  localparam logic [3:0] OP_ADDU = 4'b0001;
  localparam logic [3:0] OP_SUBU = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-2:0]   res_sh_r;
  logic [3:0]         op_r;
  logic [CW-1:0]      cnt_r;
  logic               carry_r;

  logic               accept_s;
  logic               legal_s;
  logic               bypass_s;
  logic               last_s;
  logic [WIDTH-1:0]   full_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   fin_res_s;
  logic               fin_cout_s;
  logic               fin_ovf_s;
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
  logic [WIDTH-1:0]   logic_res_s;
`endif

  assign accept_s = start_i & ready_o;
  assign last_s   = (state_r == ST_RUN) && (cnt_r == LAST);

  // Slice drive: combinational from the shift registers and carry register.
  assign slice_a_o    = a_sh_r[0];
  assign slice_b_o    = b_sh_r[0];
  assign slice_cin_o  = carry_r;
  assign slice_op_o   = (op_r == OP_SLT) ? OP_SUBU : op_r;
  assign slice_less_o = 1'b0;

  // Decode legality of the requested op and whether it skips the serial phase.
  always_comb begin
    legal_s  = 1'b0;
    bypass_s = 1'b0;
    case (op_i)
      OP_ADDU, OP_SUBU, OP_SLT: legal_s = 1'b1;
      OP_AND, OP_OR: begin
        legal_s = 1'b1;
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
        bypass_s = 1'b1;
`else
        bypass_s = 1'b0;
`endif
      end
      default: legal_s = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_LOGIC_BYPASS_EN
  // Parallel AND/OR result used when the logic ops bypass the slice.
  always_comb begin
    if (op_i == OP_AND) begin
      logic_res_s = src1_i & src2_i;
    end else begin
      logic_res_s = src1_i | src2_i;
    end
  end
`endif

  // Final-edge result and flag assembly from the last slice bit.
  always_comb begin
    full_s     = {slice_result_i, res_sh_r};
    ovf_s      = carry_r ^ slice_cout_i;
    fin_res_s  = full_s;
    fin_cout_s = slice_cout_i;
    fin_ovf_s  = ovf_s;
    case (op_r)
      OP_SLT: fin_res_s = {{(WIDTH-1){1'b0}}, slice_result_i ^ ovf_s};
      OP_AND, OP_OR: begin
        fin_cout_s = 1'b0;
        fin_ovf_s  = 1'b0;
      end
      default: fin_res_s = full_s;
    endcase
  end

  // Next-state logic: IDLE/DONE accept requests, RUN counts WIDTH bits.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (!legal_s || bypass_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (state_r == ST_DONE) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus registered handshake outputs derived from next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      done_o  <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      done_o  <= (state_nxt_s == ST_DONE);
      ready_o <= (state_nxt_s != ST_RUN);
    end
  end

  // Datapath: operand capture, bit-serial shifting and result/flag loading.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      res_sh_r   <= {(WIDTH-1){1'b0}};
      op_r       <= 4'b0000;
      cnt_r      <= {CW{1'b0}};
      carry_r    <= 1'b0;
      result_o   <= {WIDTH{1'b0}};
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= src1_i;
      b_sh_r  <= src2_i;
      op_r    <= op_i;
      cnt_r   <= {CW{1'b0}};
      carry_r <= (op_i == OP_SUBU) || (op_i == OP_SLT);
      err_o   <= 1'b0;
      if (!legal_s) begin
        result_o   <= {WIDTH{1'b0}};
        zero_o     <= 1'b0;
        cout_o     <= 1'b0;
        overflow_o <= 1'b0;
        err_o      <= 1'b1;
      end else if (bypass_s) begin
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
        result_o   <= logic_res_s;
        zero_o     <= (logic_res_s == {WIDTH{1'b0}});
`endif
        cout_o     <= 1'b0;
        overflow_o <= 1'b0;
      end
    end else if (state_r == ST_RUN) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      res_sh_r <= full_s[WIDTH-1:1];
      carry_r  <= slice_cout_i;
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        result_o   <= fin_res_s;
        zero_o     <= (fin_res_s == {WIDTH{1'b0}});
        cout_o     <= fin_cout_s;
        overflow_o <= fin_ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: randomized self-checking bench for alu_serial_seq.
// Provides a behavioural ALU_1bit slice and compares every operation with a
// whole-word arithmetic reference model.
module tb_alu_serial_seq;

  localparam int W = 32;

  localparam logic [3:0] OP_ADDU = 4'b0001;
  localparam logic [3:0] OP_SUBU = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         cout;
    logic         ovf;
    logic         err;
    logic [7:0]   lat;
    logic         done_next;
    logic [W-1:0] res_next;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         ready_o;
  logic [3:0]   op_i;
  logic [W-1:0] src1_i;
  logic [W-1:0] src2_i;
  logic [W-1:0] result_o;
  logic         zero_o, cout_o, overflow_o, err_o, done_o;
  logic         slice_a_o, slice_b_o, slice_cin_o, slice_less_o;
  logic [3:0]   slice_op_o;
  logic         slice_result_i, slice_cout_i;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .src1_i        (src1_i),
    .src2_i        (src2_i),
    .result_o      (result_o),
    .zero_o        (zero_o),
    .cout_o        (cout_o),
    .overflow_o    (overflow_o),
    .err_o         (err_o),
    .done_o        (done_o),
    .slice_a_o     (slice_a_o),
    .slice_b_o     (slice_b_o),
    .slice_cin_o   (slice_cin_o),
    .slice_op_o    (slice_op_o),
    .slice_less_o  (slice_less_o),
    .slice_result_i(slice_result_i),
    .slice_cout_i  (slice_cout_i)
  );

  always #5 clk = ~clk;

  // Behavioural one-bit ALU slice; inverts B for subtraction.
  always_comb begin
    logic b_eff;
    b_eff          = (slice_op_o == OP_SUBU) ? ~slice_b_o : slice_b_o;
    slice_result_i = 1'b0;
    slice_cout_i   = 1'b0;
    case (slice_op_o)
      OP_ADDU, OP_SUBU: begin
        slice_result_i = slice_a_o ^ b_eff ^ slice_cin_o;
        slice_cout_i   = (slice_a_o & b_eff) | (slice_a_o & slice_cin_o) | (b_eff & slice_cin_o);
      end
      OP_AND:  slice_result_i = slice_a_o & slice_b_o;
      OP_OR:   slice_result_i = slice_a_o | slice_b_o;
      default: slice_result_i = 1'b0;
    endcase
  end

  // Whole-word reference model of one operation.
  function automatic obs_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    obs_t       m;
    logic [W:0] s;
    m     = '0;
    m.lat = 8'(W + 1);
    case (op)
      OP_ADDU: begin
        s      = {1'b0, a} + {1'b0, b};
        m.res  = s[W-1:0];
        m.cout = s[W];
        m.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      OP_SUBU, OP_SLT: begin
        s      = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        m.cout = s[W];
        m.ovf  = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        if (op == OP_SUBU) m.res = s[W-1:0];
        else m.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      end
      OP_AND, OP_OR: begin
        m.res = (op == OP_AND) ? (a & b) : (a | b);
`ifdef ALU_SEQ_LOGIC_BYPASS_EN
        m.lat = 8'd1;
`endif
      end
      default: begin
        m.err = 1'b1;
        m.lat = 8'd1;
      end
    endcase
    m.zero     = (m.res == '0) && !m.err;
    m.res_next = m.res;
    return m;
  endfunction

  // Issue one operation when ready and observe result, flags and latency.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output obs_t o);
    int n;
    o = '0;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    o.res = result_o; o.zero = zero_o; o.cout = cout_o; o.ovf = overflow_o; o.err = err_o;
    o.lat = 8'(n);
    @(posedge clk); #1;
    o.done_next = done_o;
    o.res_next  = result_o;
  endtask

  task automatic test_reset();
    logic [W+6:0] got;
    rst_i = 1'b1; start_i = 1'b0; op_i = 4'b0000; src1_i = '0; src2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    got = {ready_o, done_o, result_o, zero_o, cout_o, overflow_o, err_o, slice_less_o};
    tests_run++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 5'b00000}) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", got, {1'b1, 1'b0, {W{1'b0}}, 5'b00000});
    end
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic run_and_compare(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    obs_t got, exp;
    do_op(op, a, b, got);
    exp = model(op, a, b);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s op=%b a=%h b=%h got res=%h z=%b c=%b v=%b e=%b lat=%0d dn=%b rn=%h exp res=%h z=%b c=%b v=%b e=%b lat=%0d dn=%b rn=%h",
               name, op, a, b, got.res, got.zero, got.cout, got.ovf, got.err, got.lat, got.done_next, got.res_next,
               exp.res, exp.zero, exp.cout, exp.ovf, exp.err, exp.lat, exp.done_next, exp.res_next);
    end
  endtask

  task automatic test_directed();
    run_and_compare("addu_5_3",     OP_ADDU, 32'h0000_0005, 32'h0000_0003);
    run_and_compare("addu_wrap",    OP_ADDU, 32'hFFFF_FFFF, 32'h0000_0001);
    run_and_compare("addu_ovf",     OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001);
    run_and_compare("subu_5_7",     OP_SUBU, 32'h0000_0005, 32'h0000_0007);
    run_and_compare("slt_neg_pos",  OP_SLT,  32'h8000_0000, 32'h0000_0001);
    run_and_compare("slt_7_5",      OP_SLT,  32'h0000_0007, 32'h0000_0005);
    run_and_compare("and_pattern",  OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00);
    run_and_compare("or_pattern",   OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00);
  endtask

  task automatic test_illegal();
    run_and_compare("illegal_1111", 4'b1111, 32'h1234_5678, 32'h0000_0001);
    run_and_compare("after_illegal", OP_ADDU, 32'h0000_0001, 32'h0000_0001);
  endtask

  task automatic test_random();
    logic [3:0]   legal_ops [5] = '{OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT};
    logic [W-1:0] edge_vals [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
      else op = legal_ops[$urandom_range(0, 4)];
      a = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      run_and_compare("random", op, a, b);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W+5:0] got;
    int           dones;
    run_and_compare("pre_reset_op", OP_ADDU, 32'h0000_1000, 32'h0000_0234);
    @(negedge clk);
    op_i = OP_ADDU; src1_i = 32'h0F0F_0F0F; src2_i = 32'h0101_0101; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    got = {ready_o, done_o, result_o, zero_o, cout_o, overflow_o, err_o};
    tests_run++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset_mid_run got=%h exp=%h", got, {1'b1, 1'b0, {W{1'b0}}, 4'b0000});
    end
    @(negedge clk);
    rst_i = 1'b0;
    dones = 0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_no_done got=%0d exp=0", dones);
    end
  endtask

  task automatic test_start_during_run();
    obs_t got, exp;
    int   n, dones;
    logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    got = '0;
    @(negedge clk);
    op_i = OP_SUBU; src1_i = a; src2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 200) begin
      if (n == 6) begin
        op_i = OP_OR; src1_i = ~a; src2_i = 32'hDEAD_BEEF; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    got.res = result_o; got.zero = zero_o; got.cout = cout_o; got.ovf = overflow_o; got.err = err_o;
    got.lat = 8'(n);
    @(posedge clk); #1;
    got.done_next = done_o; got.res_next = result_o;
    exp = model(OP_SUBU, a, b);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL start_in_run got res=%h lat=%0d dn=%b exp res=%h lat=%0d dn=%b",
               got.res, got.lat, got.done_next, exp.res, exp.lat, exp.done_next);
    end
    dones = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL start_in_run_no_queue got=%0d exp=0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   legal_ops [5] = '{OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT};
    logic [3:0]   op;
    logic [W-1:0] a, b;
    obs_t         exp;
    int           n;
    @(negedge clk);
    op = legal_ops[$urandom_range(0, 4)]; a = W'($urandom); b = W'($urandom);
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      n = 1;
      while (!done_o && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      exp = model(op, a, b);
      tests_run++;
      if ({result_o, zero_o, cout_o, overflow_o, err_o, 8'(n)} !== {exp.res, exp.zero, exp.cout, exp.ovf, exp.err, exp.lat}) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d op=%b got res=%h flags=%b lat=%0d exp res=%h flags=%b lat=%0d", k, op,
                 result_o, {zero_o, cout_o, overflow_o, err_o}, n, exp.res, {exp.zero, exp.cout, exp.ovf, exp.err}, exp.lat);
      end
      if (k < 3) begin
        op = legal_ops[$urandom_range(0, 4)]; a = W'($urandom); b = W'($urandom);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_reset_mid_run();
    test_start_during_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
